// File: rtl/drc_pkg.sv
// Shared widths and types for the DRC cache SRAM storage.
package drc_pkg;

    localparam int unsigned ADDR_SIZE = 24;
    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned SYN_W     = 32;
    localparam int unsigned CNT_W     = 15;
    localparam int unsigned DATA_W    = 272;

    // Tag width depends on the set count, so the tag slot is sized to the widest case.
    typedef struct packed {
        logic [TYPE_W-1:0]    typ;
        logic [SYN_W-1:0]     syn;
        logic [ADDR_SIZE-1:0] tag;
        logic [CNT_W-1:0]     cnt;
        logic [DATA_W-1:0]    data;
    } entry_t;

    typedef enum logic {IDLE, FLUSH} flush_state_t;

endpackage

// File: rtl/drc_sram_way.sv
// One way of the DRC cache SRAM: NSET entries, registered read, write-first on same index.
module drc_sram_way
    import drc_pkg::*;
#(
    parameter  int unsigned NSET  = 16,
    parameter  int unsigned TAG_W = 20,
    localparam int unsigned IDX_W = $clog2(NSET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  raddr,
    input  logic              rden,
    input  logic [IDX_W-1:0]  waddr,
    input  logic              wren,
    input  logic [TYPE_W-1:0] wtype,
    input  logic [SYN_W-1:0]  wsyn,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [CNT_W-1:0]  wcnt,
    input  logic [DATA_W-1:0] wdata,
    output logic [TYPE_W-1:0] rtype,
    output logic [SYN_W-1:0]  rsyn,
    output logic [TAG_W-1:0]  rtag,
    output logic [CNT_W-1:0]  rcnt,
    output logic [DATA_W-1:0] rdata
);

    entry_t mem_q [NSET];
    entry_t wentry;
    entry_t rdata_d, rdata_q;

    always_comb begin
        wentry      = '0;
        wentry.typ  = wtype;
        wentry.syn  = wsyn;
        wentry.tag  = ADDR_SIZE'(wtag);
        wentry.cnt  = wcnt;
        wentry.data = wdata;
    end

    // Payload storage is never reset; the valid array in the top level qualifies it.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_q[waddr] <= wentry;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rden) begin
            rdata_d = (wren && (waddr == raddr)) ? wentry : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rtype = rdata_q.typ;
    assign rsyn  = rdata_q.syn;
    assign rtag  = rdata_q.tag[TAG_W-1:0];
    assign rcnt  = rdata_q.cnt;
    assign rdata = rdata_q.data;

endmodule

// File: rtl/drc_sram_array.sv
// DRC cache SRAM responder: N_WAY ways, per-entry valid array and a one-set-per-cycle flush.
module drc_sram_array
    import drc_pkg::*;
#(
    parameter  int unsigned N_ENTRY   = 64,
    parameter  int unsigned N_WAY     = 4,
    localparam int unsigned NSET      = N_ENTRY / N_WAY,
    localparam int unsigned IDX_SIZE  = $clog2(NSET),
    localparam int unsigned TAG_SIZE  = ADDR_SIZE - IDX_SIZE,
    localparam int unsigned WAY_WIDTH = $clog2(N_WAY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_SIZE-1:0]  raddr,
    input  logic                 rden,
    output logic                 rdata_valid [N_WAY],
    output logic [TYPE_W-1:0]    rdata_type  [N_WAY],
    output logic [SYN_W-1:0]     rdata_syn   [N_WAY],
    output logic [TAG_SIZE-1:0]  rdata_tag   [N_WAY],
    output logic [CNT_W-1:0]     rdata_cnt   [N_WAY],
    output logic [DATA_W-1:0]    rdata_data  [N_WAY],
    input  logic [IDX_SIZE-1:0]  waddr,
    input  logic                 wren,
    input  logic [TYPE_W-1:0]    wdata_type,
    input  logic [SYN_W-1:0]     wdata_syn,
    input  logic [TAG_SIZE-1:0]  wdata_tag,
    input  logic [CNT_W-1:0]     wdata_cnt,
    input  logic [DATA_W-1:0]    wdata_data,
    input  logic [WAY_WIDTH-1:0] wdata_line,
    input  logic                 flush_req,
    output logic                 flush_busy
);

    flush_state_t                  state_q, state_d;
    logic [IDX_SIZE-1:0]           fidx_q, fidx_d;
    logic [NSET-1:0][N_WAY-1:0]    valid_q, valid_d;
    logic [N_WAY-1:0]              rvalid_q, rvalid_d;

    assign flush_busy = (state_q == FLUSH);

    always_comb begin
        state_d = state_q;
        fidx_d  = fidx_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (wren) begin
                    valid_d[waddr][wdata_line] = 1'b1;
                end
                if (flush_req) begin
                    state_d = FLUSH;
                    fidx_d  = '0;
                end
            end
            FLUSH: begin
                valid_d[fidx_q] = '0;
                if (fidx_q == IDX_SIZE'(NSET - 1)) begin
                    state_d = IDLE;
                    fidx_d  = '0;
                end else begin
                    fidx_d = fidx_q + IDX_SIZE'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads during a flush report every way invalid; otherwise the write-first bypass applies.
    always_comb begin
        rvalid_d = rvalid_q;
        if (rden) begin
            if (flush_busy) begin
                rvalid_d = '0;
            end else begin
                rvalid_d = valid_q[raddr];
                if (wren && (waddr == raddr)) begin
                    rvalid_d[wdata_line] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fidx_q   <= '0;
            valid_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            fidx_q   <= fidx_d;
            valid_q  <= valid_d;
            rvalid_q <= rvalid_d;
        end
    end

    for (genvar w = 0; w < N_WAY; w++) begin : g_way
        logic way_wren;
        assign way_wren = wren && !flush_busy && (wdata_line == WAY_WIDTH'(w));
        assign rdata_valid[w] = rvalid_q[w];

        drc_sram_way #(
            .NSET  (NSET),
            .TAG_W (TAG_SIZE)
        ) u_way (
            .clk   (clk),
            .rst   (rst),
            .raddr (raddr),
            .rden  (rden),
            .waddr (waddr),
            .wren  (way_wren),
            .wtype (wdata_type),
            .wsyn  (wdata_syn),
            .wtag  (wdata_tag),
            .wcnt  (wdata_cnt),
            .wdata (wdata_data),
            .rtype (rdata_type[w]),
            .rsyn  (rdata_syn[w]),
            .rtag  (rdata_tag[w]),
            .rcnt  (rdata_cnt[w]),
            .rdata (rdata_data[w])
        );
    end

endmodule
